// File: rtl/pred_box_sched.sv
// Predicted-box scheduler: pulls one box per AXI-Stream beat, hands it to the compare
// engine, and waits for engine_done before fetching the next one.
module pred_box_sched #(
  parameter int unsigned BBOX_DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH       = 16,
  parameter int unsigned MAX_BOXES       = 1024
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [BBOX_DATA_WIDTH-1:0]   s_axis_mm2s_tdata,
  input  logic [BBOX_DATA_WIDTH/8-1:0] s_axis_mm2s_tkeep,
  input  logic                         s_axis_mm2s_tlast,
  input  logic                         s_axis_mm2s_tvalid,
  output logic                         s_axis_mm2s_tready,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         engine_done,
  output logic [BBOX_DATA_WIDTH-1:0]   pred_bbox_data,
  output logic                         pbox_load,
  output logic [CNT_WIDTH-1:0]         box_count,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_keep,
  output logic                         err_ovf
);

  localparam logic [CNT_WIDTH-1:0] MaxCnt = CNT_WIDTH'(MAX_BOXES);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StWait, StDone} state_e;

  state_e                       state_q, state_d;
  logic [BBOX_DATA_WIDTH-1:0]   data_q, data_d;
  logic                         last_q, last_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic                         err_keep_q, err_keep_d;
  logic                         err_ovf_q, err_ovf_d;
  logic [CNT_WIDTH-1:0]         cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_keep_d = err_keep_q;
    err_ovf_d  = err_ovf_q;
    if (abort) begin
      // Abort beats every transition; counters and error flags are left as they are.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d    = StFetch;
            cnt_d      = '0;
            err_keep_d = 1'b0;
            err_ovf_d  = 1'b0;
          end
        end
        StFetch: begin
          if (s_axis_mm2s_tvalid) begin
            state_d = StIssue;
            data_d  = s_axis_mm2s_tdata;
            last_d  = s_axis_mm2s_tlast;
            if (!(&s_axis_mm2s_tkeep)) err_keep_d = 1'b1;
          end
        end
        StIssue: state_d = StWait;
        StWait: begin
          if (engine_done) begin
            cnt_d = cnt_inc;
            if (last_q || cnt_inc == MaxCnt) begin
              state_d = StDone;
              if (!last_q) err_ovf_d = 1'b1;
            end else begin
              state_d = StFetch;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      data_q     <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      err_keep_q <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_keep_q <= err_keep_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Control outputs are pure decodes of the state register, so tready never depends on tvalid.
  assign s_axis_mm2s_tready = (state_q == StFetch);
  assign pbox_load          = (state_q == StIssue);
  assign frame_done         = (state_q == StDone);
  assign busy               = (state_q != StIdle);
  assign pred_bbox_data     = data_q;
  assign box_count          = cnt_q;
  assign err_keep           = err_keep_q;
  assign err_ovf            = err_ovf_q;

endmodule
